// File: rtl/maze_timer_ctrl.sv
// maze_timer_ctrl
//   Game-flow controller for the maze BCD seconds timer. It runs a start
//   countdown, enables the timer while the player is in the maze, stops on
//   goal or time limit, latches the final time and keeps a best-time record.
//
// Ports:
//   i_Clk        system clock
//   i_Rst        asynchronous active-low reset
//   i_Start      one-cycle start pulse (debounced button)
//   i_Abort      one-cycle abort pulse, highest priority
//   i_Goal       one-cycle pulse when the player reaches the goal
//   i_Sec0/1     timer units/tens digit (BCD), fed back from the timer
//   o_TmrEnable  timer enable (high only in RUN); timer clears while low
//   o_State      FSM state: IDLE=0, CNTDN=1, RUN=2, DONE=3, TOUT=4
//   o_Count      countdown digit during CNTDN, else 0
//   o_Fin0/1     latched final time (BCD)
//   o_Best0/1    best completion time (BCD), 99 means no record
//   o_NewBest    one-cycle pulse when the best time is updated
module maze_timer_ctrl #(
  parameter int unsigned TICK_LAST = 99_999_999,
  parameter logic [3:0]  CNT_START = 4'd3,
  parameter logic [3:0]  LIMIT1    = 4'd6,
  parameter logic [3:0]  LIMIT0    = 4'd0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic       i_Abort,
  input  logic       i_Goal,
  input  logic [3:0] i_Sec0,
  input  logic [3:0] i_Sec1,
  output logic       o_TmrEnable,
  output logic [2:0] o_State,
  output logic [3:0] o_Count,
  output logic [3:0] o_Fin0,
  output logic [3:0] o_Fin1,
  output logic [3:0] o_Best0,
  output logic [3:0] o_Best1,
  output logic       o_NewBest
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNTDN = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_TOUT  = 3'd4
  } state_t;

  localparam logic [26:0] TICK_LAST_C = 27'(TICK_LAST);

  state_t      state_q;
  logic [3:0]  count_q;
  logic [26:0] tick_cnt_q;
  logic [26:0] tick_cnt_d;
  logic [3:0]  fin0_q, fin1_q;
  logic [3:0]  best0_q, best1_q;
  logic        newbest_q;

  logic        tick;
  logic [7:0]  sec_bcd;
  logic [7:0]  best_bcd;
  logic        is_better;
  logic        limit_hit;

  assign tick       = (tick_cnt_q == TICK_LAST_C);
  assign tick_cnt_d = tick ? 27'd0 : tick_cnt_q + 27'd1;

  // With valid BCD digits, an unsigned compare of the concatenated
  // {tens,units} byte is the same as comparing tens first, then units.
  assign sec_bcd   = {i_Sec1, i_Sec0};
  assign best_bcd  = {best1_q, best0_q};
  assign is_better = (sec_bcd < best_bcd);
  assign limit_hit = (sec_bcd == {LIMIT1, LIMIT0});

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= S_IDLE;
      count_q    <= 4'd0;
      tick_cnt_q <= 27'd0;
      fin0_q     <= 4'd0;
      fin1_q     <= 4'd0;
      best0_q    <= 4'd9;
      best1_q    <= 4'd9;
      newbest_q  <= 1'b0;
    end else begin
      newbest_q <= 1'b0;
      if (i_Abort) begin
        state_q    <= S_IDLE;
        count_q    <= 4'd0;
        tick_cnt_q <= 27'd0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_TOUT: begin
            if (i_Start) begin
              state_q    <= S_CNTDN;
              count_q    <= CNT_START;
              tick_cnt_q <= 27'd0;
            end
          end
          S_CNTDN: begin
            tick_cnt_q <= tick_cnt_d;
            if (tick) begin
              if (count_q == 4'd1) begin
                state_q <= S_RUN;
                count_q <= 4'd0;
              end else begin
                count_q <= count_q - 4'd1;
              end
            end
          end
          S_RUN: begin
            // Goal takes precedence over reaching the limit in the same cycle.
            if (i_Goal) begin
              state_q <= S_DONE;
              fin0_q  <= i_Sec0;
              fin1_q  <= i_Sec1;
              if (is_better) begin
                best0_q   <= i_Sec0;
                best1_q   <= i_Sec1;
                newbest_q <= 1'b1;
              end
            end else if (limit_hit) begin
              state_q <= S_TOUT;
              fin0_q  <= LIMIT0;
              fin1_q  <= LIMIT1;
            end
          end
          default: begin
            state_q    <= S_IDLE;
            count_q    <= 4'd0;
            tick_cnt_q <= 27'd0;
          end
        endcase
      end
    end
  end

  assign o_TmrEnable = (state_q == S_RUN);
  assign o_State     = state_q;
  assign o_Count     = count_q;
  assign o_Fin0      = fin0_q;
  assign o_Fin1      = fin1_q;
  assign o_Best0     = best0_q;
  assign o_Best1     = best1_q;
  assign o_NewBest   = newbest_q;

endmodule

// File: tb/tb_maze_timer_ctrl.sv
module tb_maze_timer_ctrl;

  localparam int TL   = 3;
  localparam int CS   = 3;
  localparam int LIM1 = 0;
  localparam int LIM0 = 5;
  localparam int LIM  = LIM1 * 10 + LIM0;
  localparam int TDIV = 4;   // timer model: cycles per timer second

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b0;
  logic       i_Start = 1'b0;
  logic       i_Abort = 1'b0;
  logic       i_Goal = 1'b0;
  logic [3:0] i_Sec0 = 4'd0;
  logic [3:0] i_Sec1 = 4'd0;
  logic       o_TmrEnable;
  logic [2:0] o_State;
  logic [3:0] o_Count;
  logic [3:0] o_Fin0, o_Fin1, o_Best0, o_Best1;
  logic       o_NewBest;

  maze_timer_ctrl #(
    .TICK_LAST(TL),
    .CNT_START(4'(CS)),
    .LIMIT1(4'(LIM1)),
    .LIMIT0(4'(LIM0))
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Start(i_Start),
    .i_Abort(i_Abort),
    .i_Goal(i_Goal),
    .i_Sec0(i_Sec0),
    .i_Sec1(i_Sec1),
    .o_TmrEnable(o_TmrEnable),
    .o_State(o_State),
    .o_Count(o_Count),
    .o_Fin0(o_Fin0),
    .o_Fin1(o_Fin1),
    .o_Best0(o_Best0),
    .o_Best1(o_Best1),
    .o_NewBest(o_NewBest)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic       en;
    logic [2:0] st;
    logic [3:0] cnt;
    logic [3:0] f1;
    logic [3:0] f0;
    logic [3:0] b1;
    logic [3:0] b0;
    logic       nb;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   checks = 0;
  int   errors = 0;

  // Reference model: game phase, cycles left in the countdown, times as
  // plain integers (seconds), and an integer-second timer.
  int m_st;     // 0 idle, 1 countdown, 2 run, 3 done, 4 timeout
  int m_rem;
  int m_fin;
  int m_best;
  bit m_nb;
  int t_sec;
  int t_pre;

  function automatic obs_t model_obs();
    obs_t o;
    o.en  = (m_st == 2);
    o.st  = 3'(m_st);
    o.cnt = (m_st == 1) ? 4'((m_rem + TL) / (TL + 1)) : 4'd0;
    o.f1  = 4'(m_fin / 10);
    o.f0  = 4'(m_fin % 10);
    o.b1  = 4'(m_best / 10);
    o.b0  = 4'(m_best % 10);
    o.nb  = m_nb;
    return o;
  endfunction

  task automatic model_reset();
    m_st = 0; m_rem = 0; m_fin = 0; m_best = 99; m_nb = 0;
    t_sec = 0; t_pre = 0;
  endtask

  // One clock cycle: drive pulses and the timer digits, advance the model
  // across the coming edge and queue the expected post-edge outputs.
  task automatic step(input bit s, input bit a, input bit g);
    int sec_now;
    @(negedge i_Clk);
    i_Start = s; i_Abort = a; i_Goal = g;
    i_Sec1 = 4'(t_sec / 10);
    i_Sec0 = 4'(t_sec % 10);
    sec_now = t_sec;
    if (m_st == 2) begin
      t_pre++;
      if (t_pre == TDIV) begin
        t_pre = 0;
        t_sec = (t_sec + 1) % 100;
      end
    end else begin
      t_pre = 0;
      t_sec = 0;
    end
    m_nb = 0;
    if (a) begin
      m_st = 0; m_rem = 0;
    end else begin
      case (m_st)
        0, 3, 4: if (s) begin m_st = 1; m_rem = CS * (TL + 1); end
        1: begin
          m_rem--;
          if (m_rem == 0) m_st = 2;
        end
        2: begin
          if (g) begin
            m_st = 3; m_fin = sec_now;
            if (sec_now < m_best) begin m_best = sec_now; m_nb = 1; end
          end else if (sec_now == LIM) begin
            m_st = 4; m_fin = LIM;
          end
        end
        default: m_st = 0;
      endcase
    end
    exp_q.push_back(model_obs());
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({o_TmrEnable, o_State, o_Count, o_Fin1, o_Fin0, o_Best1, o_Best0, o_NewBest}
        !== {1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd9, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL %s: got en=%0b st=%0d cnt=%0d fin=%0d%0d best=%0d%0d nb=%0b, expected en=0 st=0 cnt=0 fin=00 best=99 nb=0",
               name, o_TmrEnable, o_State, o_Count, o_Fin1, o_Fin0, o_Best1, o_Best0, o_NewBest);
    end
  endtask

  // Asserts reset between clock edges and checks it takes effect at once.
  task automatic async_reset();
    @(negedge i_Clk);
    i_Start = 0; i_Abort = 0; i_Goal = 0;
    #2 i_Rst = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    @(posedge i_Clk);
    @(negedge i_Clk);
    #1 i_Rst = 1'b1;
  endtask

  task automatic run_until_sec(input int target);
    int n = 0;
    while (!(m_st == 2 && t_sec == target) && n < 200) begin
      step(0, 0, 0);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL run_until_sec: timer never reached %0d within 200 cycles (model state %0d)", target, m_st);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  // Monitor: compares the DUT against each queued expectation after the edge.
  initial begin
    forever begin
      @(posedge i_Clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_a = {o_TmrEnable, o_State, o_Count, o_Fin1, o_Fin0, o_Best1, o_Best0, o_NewBest};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL outputs @%0t: got en=%0b st=%0d cnt=%0d fin=%0d%0d best=%0d%0d nb=%0b, expected en=%0b st=%0d cnt=%0d fin=%0d%0d best=%0d%0d nb=%0b",
                   $time, mon_a.en, mon_a.st, mon_a.cnt, mon_a.f1, mon_a.f0, mon_a.b1, mon_a.b0, mon_a.nb,
                   mon_e.en, mon_e.st, mon_e.cnt, mon_e.f1, mon_e.f0, mon_e.b1, mon_e.b0, mon_e.nb);
        end
      end
    end
  end

  initial begin
    model_reset();
    #12 check_reset_vals("reset_state");
    @(negedge i_Clk);
    #1 i_Rst = 1'b1;

    // Countdown, then reset in the middle of it.
    step(1, 0, 0);
    idle_cycles(5);
    async_reset();

    // Full countdown into RUN, goal at 02: first record.
    step(1, 0, 0);
    run_until_sec(2);
    step(0, 0, 1);
    idle_cycles(3);

    // Goal at 03: slower, record kept.
    step(1, 0, 0);
    run_until_sec(3);
    step(0, 0, 1);
    idle_cycles(2);

    // No goal: time limit reached.
    step(1, 0, 0);
    run_until_sec(LIM);
    idle_cycles(3);

    // Goal on the limit cycle: goal wins.
    step(1, 0, 0);
    run_until_sec(LIM);
    step(0, 0, 1);
    idle_cycles(2);

    // Start ignored in RUN, abort beats goal, goal ignored in IDLE.
    step(1, 0, 0);
    run_until_sec(1);
    step(1, 0, 0);
    step(0, 1, 1);
    step(0, 0, 1);
    idle_cycles(2);

    // Equal to the current best (02) is not a new record.
    step(1, 0, 0);
    run_until_sec(2);
    step(0, 0, 1);
    step(0, 0, 1);
    idle_cycles(2);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 9) == 0);
      end
    end

    idle_cycles(2);
    @(negedge i_Clk);
    i_Start = 0; i_Abort = 0; i_Goal = 0;
    @(negedge i_Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
